seven_seg_scan_sched: RTL and testbench
=======================================

// Module: seven_seg_scan_sched
// PURPOSE
// - Display scheduler for the vending machine's 8-digit multiplexed seven-segment display.
// - Holds an 8-entry digit frame buffer that two requesters share through a request/ack arbiter:
//   - A: vend FSM (money/candy totals).
//   - B: message/service logic.
// - Scans one digit per slot with a blanking dead-time to suppress ghosting.
// - Feeds data_out into the existing BCD-to-segment decoder. Code 4'hA is the blank glyph.
// PARAMETERS
// - CLK_DIV    default 50000  clk cycles per digit slot (BLANK + DRIVE); legal range BLANK_CYC+1 .. 65535
// - BLANK_CYC  default 16     cycles per slot with all columns off; legal range 1 .. CLK_DIV-1
// - STARVE_MAX default 2      consecutive A grants while B waits before B is forced a grant; legal range 1..7
// PORTS
// - clk             in   1  system clock, rising edge
// - reset_n         in   1  asynchronous, active-low reset
// - enable          in   1  scan enable; 0 = display dark
// - a_wr            in   1  requester A write request; held until a_ack
// - a_idx           in   3  A digit index 0..7
// - a_data          in   4  A digit code
// - a_ack           out  1  one-cycle pulse: A write committed
// - b_wr/b_idx/b_data  in  1/3/4  requester B, same rules as A
// - b_ack           out  1  one-cycle pulse: B write committed
// - data_out        out  4  digit code for the currently scheduled digit
// - display_column  out  8  column enables, active-low, bit n = digit n
// - frame_sync      out  1  one-cycle pulse on entry to DRIVE of digit 0
// BEHAVIOUR
// - Reset (async, immediate):
//   - Frame buffer all 4'hA; data_out=4'hA; display_column=8'hFF.
//   - a_ack=b_ack=frame_sync=0; state IDLE; digit=0; slot counter=0; starve count=0.
// - Scan FSM:
//   - IDLE: outputs dark (8'hFF, 4'hA). When enable=1, go to BLANK for digit 0 on the next edge.
//   - BLANK: held for BLANK_CYC cycles; display_column=8'hFF.
//     - data_out is loaded on the edge entering BLANK from the pre-edge buffer contents of that digit.
//     - A write on that same edge is seen on the next visit, not this one.
//   - DRIVE: held for CLK_DIV-BLANK_CYC cycles; display_column=~(8'b1<<digit); data_out stable.
//     - At the end of DRIVE: digit wraps 7->0, then go to BLANK.
// - enable=0 in any state: next edge goes to IDLE and clears digit and counter; outputs dark on that edge.
// - Slot counter: 16 bits; counts 0..CLK_DIV-1 and wraps.
// - Arbiter: at most one buffer write per cycle.
//   - A has priority.
//   - If B is requesting and A has won STARVE_MAX consecutive grants, B wins the next grant.
//     - The starve count resets on any B grant, or on any cycle B is not requesting.
//   - A granted write updates the buffer on the edge and asserts the requester's ack in the following cycle.
//   - The requester must deassert wr in the cycle it sees ack. A wr still high in that cycle is treated as a new request.
//   - Two requests to the same idx: last committed grant wins.
// - Buffer writes never disturb the digit currently in DRIVE.
// CONFIGURATION
// - SEVEN_SEG_LAMP_TEST_EN defined:
//   - Adds input lamp_test (1 bit).
//   - While lamp_test=1: data_out is forced to 4'h8 in BLANK and DRIVE; scan timing is unchanged; buffer writes/acks still work.
//   - On release, the normal digit code resumes at the next BLANK entry.
// - Macro undefined: no lamp_test port, no override logic.
// TESTING (CLK_DIV=8, BLANK_CYC=2, STARVE_MAX=2)
// - Reset, then enable=1:
//   - display_column 8'hFF for 2 cycles, then 8'hFE for 6 cycles, then FF x2, FD x6 ... 7F.
//   - Then wraps to FE; frame_sync pulses once per 64 cycles; data_out=4'hA throughout.
// - A writes idx3=4'h5 (held until ack): a_ack pulses 1 cycle later.
//   - data_out=4'h5 while display_column=8'hF7.
// - a_wr and b_wr held continuously:
//   - Grant order A,A,B,A,A,B...; a_ack and b_ack are never high in the same cycle.
// - Write idx0=4'h7 while digit 0 is in DRIVE:
//   - data_out stays 4'hA for the current slot; 4'h7 appears on the next digit-0 slot.
// - Drop enable mid-DRIVE of digit 5:
//   - Next edge: 8'hFF/4'hA. Re-enable: scan restarts at digit 0 with BLANK.
// - Assert reset_n=0 mid-scan, asynchronously between edges:
//   - All outputs go to reset values immediately and the buffer reads back 4'hA.
//   - With SEVEN_SEG_LAMP_TEST_EN: lamp_test=1 gives data_out=4'h8 on every slot.

Source files
------------

// File: rtl/seven_seg_scan_sched.sv
// Eight-digit multiplexed seven-segment scan scheduler with a shared frame buffer and an A/B write arbiter.
// Optional lamp test (forces glyph 8) is enabled by defining SEVEN_SEG_LAMP_TEST_EN.
module seven_seg_scan_sched #(
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int STARVE_MAX = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       a_wr,
    input  logic [2:0] a_idx,
    input  logic [3:0] a_data,
    output logic       a_ack,
    input  logic       b_wr,
    input  logic [2:0] b_idx,
    input  logic [3:0] b_data,
    output logic       b_ack,
`ifdef SEVEN_SEG_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    output logic [3:0] data_out,
    output logic [7:0] display_column,
    output logic       frame_sync,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BLANK = 2'd1, S_DRIVE = 2'd2} state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic [15:0] SLOT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [3:0]  GLYPH_BLANK = 4'hA;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      digit_q, digit_d;
    logic [3:0]      data_out_q, data_out_d;
    logic            frame_sync_q, frame_sync_d;
    logic [7:0][3:0] buf_q, buf_d;
    logic [2:0]      starve_q, starve_d;
    logic            a_ack_q, a_ack_d;
    logic            b_ack_q, b_ack_d;
    logic            load_digit;
    logic            grant_a, grant_b;
    logic            lamp_on;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            digit_q      <= '0;
            data_out_q   <= GLYPH_BLANK;
            frame_sync_q <= 1'b0;
            buf_q        <= {8{GLYPH_BLANK}};
            starve_q     <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            data_out_q   <= data_out_d;
            frame_sync_q <= frame_sync_d;
            buf_q        <= buf_d;
            starve_q     <= starve_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
        end
    end

    // Next-state: BLANK covers slot counts 0..BLANK_CYC-1, DRIVE the rest of the slot
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        load_digit   = 1'b0;
        frame_sync_d = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_BLANK;
                    cnt_d      = '0;
                    digit_d    = '0;
                    load_digit = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d      = S_DRIVE;
                        frame_sync_d = (digit_q == 3'd0);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d    = S_BLANK;
                        cnt_d      = '0;
                        digit_d    = digit_q + 3'd1;
                        load_digit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // Digit code is latched only at BLANK entry, so writes never reach the slot already scheduled
    always_comb begin
        data_out_d = data_out_q;
        if (state_d == S_IDLE) data_out_d = GLYPH_BLANK;
        else if (load_digit)   data_out_d = buf_q[digit_d];
    end

    // Arbiter: A wins unless B has waited through STARVE_MAX consecutive A grants
    always_comb begin
        grant_b  = b_wr && (!a_wr || (starve_q >= STARVE_LIM));
        grant_a  = a_wr && !grant_b;
        buf_d    = buf_q;
        starve_d = starve_q;
        if (grant_a)      buf_d[a_idx] = a_data;
        else if (grant_b) buf_d[b_idx] = b_data;
        if (!b_wr || grant_b)               starve_d = '0;
        else if (grant_a && starve_q != 3'd7) starve_d = starve_q + 3'd1;
        a_ack_d = grant_a;
        b_ack_d = grant_b;
    end

`ifdef SEVEN_SEG_LAMP_TEST_EN
    logic lamp_hold_q, lamp_hold_d;

    // Holds the override after release until the next digit load
    always_comb begin
        lamp_hold_d = lamp_hold_q;
        if (lamp_test)       lamp_hold_d = 1'b1;
        else if (load_digit) lamp_hold_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lamp_hold_q <= 1'b0;
        else          lamp_hold_q <= lamp_hold_d;
    end

    assign lamp_on = lamp_test | lamp_hold_q;
`else
    assign lamp_on = 1'b0;
`endif

    // Outputs
    always_comb begin
        display_column = 8'hFF;
        data_out       = GLYPH_BLANK;
        if (state_q == S_DRIVE) display_column = ~(8'b1 << digit_q);
        if (state_q != S_IDLE)  data_out = lamp_on ? 4'h8 : data_out_q;
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign frame_sync = frame_sync_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seven_seg_scan_sched.sv
// Directed bench for seven_seg_scan_sched at CLK_DIV=8, BLANK_CYC=2, STARVE_MAX=2.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_seven_seg_scan_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       a_wr = 1'b0;
    logic [2:0] a_idx = '0;
    logic [3:0] a_data = '0;
    logic       a_ack;
    logic       b_wr = 1'b0;
    logic [2:0] b_idx = '0;
    logic [3:0] b_data = '0;
    logic       b_ack;
`ifdef SEVEN_SEG_LAMP_TEST_EN
    logic       lamp_test = 1'b0;
`endif
    logic [3:0] data_out;
    logic [7:0] display_column;
    logic       frame_sync;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    seven_seg_scan_sched #(.CLK_DIV(8), .BLANK_CYC(2), .STARVE_MAX(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .a_wr(a_wr), .a_idx(a_idx), .a_data(a_data), .a_ack(a_ack),
        .b_wr(b_wr), .b_idx(b_idx), .b_data(b_data), .b_ack(b_ack),
`ifdef SEVEN_SEG_LAMP_TEST_EN
        .lamp_test(lamp_test),
`endif
        .data_out(data_out), .display_column(display_column),
        .frame_sync(frame_sync), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] col;
        int         len;
    } slot_t;

    typedef struct {
        logic       use_b;
        logic [2:0] idx;
        logic [3:0] data;
        logic [7:0] col;
        logic [3:0] exp;
    } wr_vec_t;

    slot_t   st[16];
    wr_vec_t wv[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_col(input logic [7:0] target);
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (display_column == target) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_col", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_fs();
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_sync) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_frame_sync", {31'd0, found}, 32'd1);
    endtask

    // Called at a falling edge; holds the request until its ack, then drops it
    task automatic do_write(input logic use_b, input logic [2:0] idx, input logic [3:0] data);
        logic got = 1'b0;
        if (use_b) begin b_wr = 1'b1; b_idx = idx; b_data = data; end
        else       begin a_wr = 1'b1; a_idx = idx; a_data = data; end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((use_b ? b_ack : a_ack) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("write_ack", {31'd0, got}, 32'd1);
        a_wr = 1'b0;
        b_wr = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", {30'd0, a_ack, b_ack}, 32'd0);
    endtask

    initial begin
        logic exp_a[9];

        st[0]  = '{8'hFF, 2}; st[1]  = '{8'hFE, 6};
        st[2]  = '{8'hFF, 2}; st[3]  = '{8'hFD, 6};
        st[4]  = '{8'hFF, 2}; st[5]  = '{8'hFB, 6};
        st[6]  = '{8'hFF, 2}; st[7]  = '{8'hF7, 6};
        st[8]  = '{8'hFF, 2}; st[9]  = '{8'hEF, 6};
        st[10] = '{8'hFF, 2}; st[11] = '{8'hDF, 6};
        st[12] = '{8'hFF, 2}; st[13] = '{8'hBF, 6};
        st[14] = '{8'hFF, 2}; st[15] = '{8'h7F, 6};

        wv[0] = '{1'b0, 3'd3, 4'h5, 8'hF7, 4'h5};
        wv[1] = '{1'b1, 3'd6, 4'hC, 8'hBF, 4'hC};
        wv[2] = '{1'b0, 3'd3, 4'h9, 8'hF7, 4'h9};
        wv[3] = '{1'b1, 3'd7, 4'h0, 8'h7F, 4'h0};
        wv[4] = '{1'b0, 3'd1, 4'h2, 8'hFD, 4'h2};

        exp_a = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", {24'd0, display_column}, 32'hFF);
        check("rst_data", {28'd0, data_out}, 32'hA);
        check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_fsync", {31'd0, frame_sync}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_col", {24'd0, display_column}, 32'hFF);

        // Full scan plus wrap into the next frame
        enable = 1'b1;
        for (int e = 0; e < 18; e++) begin
            for (int k = 0; k < st[e % 16].len; k++) begin
                @(negedge clk);
                check("scan_col", {24'd0, display_column}, {24'd0, st[e % 16].col});
                check("scan_data", {28'd0, data_out}, 32'hA);
                check("scan_fsync", {31'd0, frame_sync}, {31'd0, ((e % 16) == 1 && k == 0)});
            end
        end

        // Writes through A and B, checked on the owning digit's slot
        for (int v = 0; v < 5; v++) begin
            do_write(wv[v].use_b, wv[v].idx, wv[v].data);
            wait_fs();
            wait_col(wv[v].col);
            check("wr_data", {28'd0, data_out}, {28'd0, wv[v].exp});
        end

        // Both requesters held: A,A,B repeating, never both acked
        @(negedge clk);
        a_wr = 1'b1; a_idx = 3'd2; a_data = 4'h3;
        b_wr = 1'b1; b_idx = 3'd4; b_data = 4'h4;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("arb_a_ack", {31'd0, a_ack}, {31'd0, exp_a[i]});
            check("arb_b_ack", {31'd0, b_ack}, {31'd0, !exp_a[i]});
        end
        a_wr = 1'b0;
        b_wr = 1'b0;
        @(negedge clk);
        check("arb_idle_acks", {30'd0, a_ack, b_ack}, 32'd0);

        // Write digit 0 while it is being driven
        wait_fs();
        check("d0_col", {24'd0, display_column}, 32'hFE);
        do_write(1'b0, 3'd0, 4'h7);
        for (int i = 0; i < 8; i++) begin
            if (display_column != 8'hFE) break;
            check("d0_stable", {28'd0, data_out}, 32'hA);
            @(negedge clk);
        end
        wait_fs();
        check("d0_next_slot", {28'd0, data_out}, 32'h7);

        // Drop enable during digit 5 drive, then restart
        wait_col(8'hDF);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dis_col", {24'd0, display_column}, 32'hFF);
            check("dis_data", {28'd0, data_out}, 32'hA);
        end
        enable = 1'b1;
        @(negedge clk);
        check("re_blank_col", {24'd0, display_column}, 32'hFF);
        check("re_blank_data", {28'd0, data_out}, 32'h7);
        @(negedge clk);
        check("re_blank2_col", {24'd0, display_column}, 32'hFF);
        @(negedge clk);
        check("re_drive_col", {24'd0, display_column}, 32'hFE);
        check("re_fsync", {31'd0, frame_sync}, 32'd1);

        // Asynchronous reset between edges during digit 3 drive
        wait_col(8'hF7);
        check("pre_rst_data", {28'd0, data_out}, 32'h9);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_col", {24'd0, display_column}, 32'hFF);
        check("arst_data", {28'd0, data_out}, 32'hA);
        check("arst_fsync", {31'd0, frame_sync}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_col(8'hF7);
        check("post_rst_d3", {28'd0, data_out}, 32'hA);
        wait_col(8'hBF);
        check("post_rst_d6", {28'd0, data_out}, 32'hA);

`ifdef SEVEN_SEG_LAMP_TEST_EN
        lamp_test = 1'b1;
        for (int d = 0; d < 8; d++) begin
            logic [7:0] col_t = 8'h01;
            col_t = ~(col_t << d);
            wait_col(col_t);
            check("lamp_data", {28'd0, data_out}, 32'h8);
        end
        lamp_test = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
